// File: rtl/oam_dma_controller.sv
// Sprite DMA engine. A CPU write to DMA_REG_ADDR halts the CPU and copies
// 256 bytes from page {page,8'h00} into the PPU OAM data port.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        clock_EN,
  input  logic        cpuWrite,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuData_IN,
  input  logic [7:0]  memData_IN,
  output logic        cpuHalt,
  output logic        busGrant,
  output logic [15:0] dmaAddress,
  output logic        dmaRW,
  output logic        oamWrite_EN,
  output logic [7:0]  oamData_OUT,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} stateT;

  typedef struct packed {
    logic        busy;
    logic        cpuHalt;
    logic        busGrant;
    logic [15:0] dmaAddress;
    logic        dmaRW;
    logic        oamWrite_EN;
    logic [7:0]  oamData_OUT;
  } outT;

  stateT      state;
  logic       putCycle;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] dataReg;
  logic [7:0] indexInc;
  outT        outR;

  assign indexInc = index + 8'd1;

  // Output word for a given state; registered alongside the state transition
  function automatic outT decode(input stateT s, input logic [7:0] pg,
                                 input logic [7:0] idx, input logic [7:0] d);
    outT o;
    o         = '0;
    o.dmaRW   = 1'b1;
    o.busy    = (s != IDLE);
    o.cpuHalt = (s != IDLE);
    case (s)
      READ: begin
        o.busGrant   = 1'b1;
        o.dmaAddress = {pg, idx};
      end
      WRITE: begin
        o.busGrant    = 1'b1;
        o.dmaAddress  = OAM_DATA_ADDR;
        o.dmaRW       = 1'b0;
        o.oamWrite_EN = 1'b1;
        o.oamData_OUT = d;
      end
      default: ;
    endcase
    return o;
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      putCycle <= 1'b0;
      page     <= 8'h00;
      index    <= 8'h00;
      dataReg  <= 8'h00;
      outR     <= decode(IDLE, 8'h00, 8'h00, 8'h00);
    end else if (clock_EN) begin
      putCycle <= ~putCycle;
      case (state)
        IDLE: begin
          if (cpuWrite && (cpuAddress == DMA_REG_ADDR)) begin
            page  <= cpuData_IN;
            index <= 8'h00;
            state <= HALT;
            outR  <= decode(HALT, cpuData_IN, 8'h00, dataReg);
          end
        end
        HALT: begin
          // A put-cycle trigger goes straight to READ; a get-cycle trigger
          // needs one extra ALIGN cycle.
          if (!putCycle) begin
            state <= READ;
            outR  <= decode(READ, page, index, dataReg);
          end else begin
            state <= ALIGN;
            outR  <= decode(ALIGN, page, index, dataReg);
          end
        end
        ALIGN: begin
          state <= READ;
          outR  <= decode(READ, page, index, dataReg);
        end
        READ: begin
          dataReg <= memData_IN;
          state   <= WRITE;
          outR    <= decode(WRITE, page, index, memData_IN);
        end
        WRITE: begin
          index <= indexInc;
          if (index == 8'hFF) begin
            state <= IDLE;
            outR  <= decode(IDLE, page, indexInc, dataReg);
          end else begin
            state <= READ;
            outR  <= decode(READ, page, indexInc, dataReg);
          end
        end
        default: begin
          state <= IDLE;
          outR  <= decode(IDLE, page, index, dataReg);
        end
      endcase
    end
  end

  assign busy        = outR.busy;
  assign cpuHalt     = outR.cpuHalt;
  assign busGrant    = outR.busGrant;
  assign dmaAddress  = outR.dmaAddress;
  assign dmaRW       = outR.dmaRW;
  assign oamWrite_EN = outR.oamWrite_EN;
  assign oamData_OUT = outR.oamData_OUT;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: a small memory model feeds reads,
// and each transfer's reads, OAM writes and busy length are collected.
module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        clock_EN = 1'b1;
  logic        cpuWrite = 1'b0;
  logic [15:0] cpuAddress = 16'h0000;
  logic [7:0]  cpuData_IN = 8'h00;
  logic [7:0]  memData_IN;
  logic        cpuHalt, busGrant, dmaRW, oamWrite_EN, busy;
  logic [15:0] dmaAddress;
  logic [7:0]  oamData_OUT;

  int nTotal = 0;
  int nBad   = 0;

  logic [15:0] rdQ[$];
  logic [7:0]  wrQ[$];
  int          busyCnt = 0;
  int          haltCnt = 0;
  int          wrAddrBad = 0;
  logic        putModel;

  oam_dma_controller dut (
    .clock(clock), .resetN(resetN), .clock_EN(clock_EN), .cpuWrite(cpuWrite),
    .cpuAddress(cpuAddress), .cpuData_IN(cpuData_IN), .memData_IN(memData_IN),
    .cpuHalt(cpuHalt), .busGrant(busGrant), .dmaAddress(dmaAddress),
    .dmaRW(dmaRW), .oamWrite_EN(oamWrite_EN), .oamData_OUT(oamData_OUT),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] memByte(input logic [15:0] a);
    logic [7:0] hi3;
    hi3 = a[15:8] * 8'd3;
    return a[7:0] ^ hi3 ^ 8'h5C;
  endfunction

  assign memData_IN = memByte(dmaAddress);

  // Cycle parity as seen by the bench: toggles on every enabled edge
  always @(posedge clock or negedge resetN)
    if (!resetN) putModel <= 1'b0;
    else if (clock_EN) putModel <= ~putModel;

  always @(negedge clock) begin
    if (resetN && clock_EN) begin
      if (busy) busyCnt++;
      if (busy && !busGrant) haltCnt++;
      if (busGrant && dmaRW) rdQ.push_back(dmaAddress);
      if (oamWrite_EN) begin
        wrQ.push_back(oamData_OUT);
        if (dmaAddress != 16'h2004 || dmaRW) wrAddrBad++;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearStats();
    rdQ.delete();
    wrQ.delete();
    busyCnt   = 0;
    haltCnt   = 0;
    wrAddrBad = 0;
  endtask

  task automatic kick(input logic [7:0] pg, input logic wantPut);
    @(posedge clock); #1;
    if (putModel != wantPut) begin @(posedge clock); #1; end
    cpuWrite   = 1'b1;
    cpuAddress = 16'h4014;
    cpuData_IN = pg;
    @(posedge clock); #1;
    cpuWrite   = 1'b0;
    cpuAddress = 16'h0000;
  endtask

  task automatic waitIdle(input string tag);
    int i;
    for (i = 0; i < 3000 && busy; i++) @(negedge clock);
    if (busy) checkVal({tag, "_timeout"}, 32'd1, 32'd0);
    #1;
  endtask

  task automatic checkXfer(input string tag, input logic [7:0] pg, input int expBusy);
    int rBad, dBad;
    rBad = 0;
    dBad = 0;
    for (int i = 0; i < rdQ.size(); i++)
      if (rdQ[i] != {pg, i[7:0]}) rBad++;
    for (int i = 0; i < wrQ.size(); i++)
      if (wrQ[i] != memByte({pg, i[7:0]})) dBad++;
    checkVal({tag, "_busy"}, busyCnt, expBusy);
    checkVal({tag, "_nRead"}, rdQ.size(), 256);
    checkVal({tag, "_nWrite"}, wrQ.size(), 256);
    checkVal({tag, "_readAddr"}, rBad, 0);
    checkVal({tag, "_data"}, dBad, 0);
  endtask

  initial begin
    int i;
    // reset values
    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_halt", cpuHalt, 1'b0);
    checkVal("rst_grant", busGrant, 1'b0);
    checkVal("rst_rw", dmaRW, 1'b1);
    checkVal("rst_addr", dmaAddress, 16'h0000);
    checkVal("rst_we", oamWrite_EN, 1'b0);
    checkVal("rst_data", oamData_OUT, 8'h00);
    resetN = 1'b1;

    // put-cycle trigger, page 02
    clearStats();
    kick(8'h02, 1'b1);
    checkVal("put_busyStart", busy, 1'b1);
    waitIdle("put");
    checkXfer("put", 8'h02, 513);
    checkVal("put_first", rdQ[0], 16'h0200);
    checkVal("put_last", rdQ[255], 16'h02FF);
    checkVal("put_haltCycles", haltCnt, 1);
    checkVal("put_wrAddr", wrAddrBad, 0);

    // get-cycle trigger needs one ALIGN cycle
    clearStats();
    kick(8'h02, 1'b0);
    waitIdle("get");
    checkXfer("get", 8'h02, 514);
    checkVal("get_haltCycles", haltCnt, 2);

    // retrigger while busy at index 40 is ignored
    clearStats();
    kick(8'h02, 1'b1);
    for (i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (busGrant && dmaRW && dmaAddress == 16'h0240) break;
    end
    checkVal("ign_reached", dmaAddress, 16'h0240);
    #1;
    cpuWrite = 1'b1; cpuAddress = 16'h4014; cpuData_IN = 8'h05;
    @(posedge clock); #1;
    cpuWrite = 1'b0; cpuAddress = 16'h0000;
    waitIdle("ign");
    checkXfer("ign", 8'h02, 513);

    // reset during READ of index 80 aborts the transfer
    clearStats();
    kick(8'h02, 1'b1);
    for (i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (busGrant && dmaRW && dmaAddress == 16'h0280) break;
    end
    checkVal("abort_reached", dmaAddress, 16'h0280);
    #1;
    resetN = 1'b0;
    #1;
    checkVal("abort_busy", busy, 1'b0);
    checkVal("abort_we", oamWrite_EN, 1'b0);
    checkVal("abort_rw", dmaRW, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checkVal("abort_nWrite", wrQ.size(), 128);
    checkVal("abort_idle", busy, 1'b0);
    clearStats();
    kick(8'h03, 1'b1);
    waitIdle("after");
    checkXfer("after", 8'h03, 513);

    // clock_EN low for 3 clocks during a WRITE
    clearStats();
    kick(8'h04, 1'b1);
    for (i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      if (oamWrite_EN && wrQ.size() == 20) break;
    end
    checkVal("stall_reached", oamWrite_EN, 1'b1);
    clock_EN = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      checkVal("stall_we", oamWrite_EN, 1'b1);
    end
    checkVal("stall_data", oamData_OUT, memByte(16'h0414));
    clock_EN = 1'b1;
    waitIdle("stall");
    checkXfer("stall", 8'h04, 513);

    // page FF stays inside the page
    clearStats();
    kick(8'hFF, 1'b1);
    waitIdle("pgFF");
    checkXfer("pgFF", 8'hFF, 513);
    checkVal("pgFF_last", rdQ[rdQ.size()-1], 16'hFFFF);
    repeat (4) @(posedge clock);
    #1;
    checkVal("pgFF_idleBusy", busy, 1'b0);
    checkVal("pgFF_idleGrant", busGrant, 1'b0);
    checkVal("pgFF_idleAddr", dmaAddress, 16'h0000);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
